// File: rtl/scanchain_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : scanchain_write_arbiter
//  Purpose  : Round-robin arbiter with per-requester lock that shares one
//             scanchain writer among NUM_REQ sources, one write per grant.
//  Revision : 1.0  initial release
// ============================================================================

module scanchain_write_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_BITS    = 12,
  parameter int PAYLOAD_BITS = 160,
  parameter int ID_BITS      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_payload,
  input  logic [NUM_REQ-1:0]              req_reset,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic                            write_ready,
  output logic                            write_valid,
  output logic [ADDR_BITS-1:0]            write_addr,
  output logic [PAYLOAD_BITS-1:0]         write_payload,
  output logic                            write_reset,
  output logic [ID_BITS-1:0]              grant_id,
  output logic                            busy
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_GAP   = 2'd2;

  // Requester 0 gets first priority out of reset.
  localparam logic [ID_BITS-1:0] c_GRANT_RST = ID_BITS'(NUM_REQ - 1);

  logic [1:0]              state_q;
  logic [1:0]              state_d;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [PAYLOAD_BITS-1:0] payload_q;
  logic                    wreset_q;
  logic [ID_BITS-1:0]      grant_q;
  logic                    locked_q;

  logic                    w_win_found;
  logic [ID_BITS-1:0]      w_win_id;
  logic                    w_accept;

  logic [ADDR_BITS-1:0]    w_addr_arr    [NUM_REQ];
  logic [PAYLOAD_BITS-1:0] w_payload_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr_arr[gi]    = req_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign w_payload_arr[gi] = req_payload[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  endgenerate

  // Round-robin: lowest valid index above grant_q wins, else lowest at or below.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = grant_q;
    if (locked_q) begin
      w_win_found = req_valid[grant_q];
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i] && (i <= int'(grant_q))) begin
          w_win_found = 1'b1;
          w_win_id    = ID_BITS'(i);
        end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i] && (i > int'(grant_q))) begin
          w_win_found = 1'b1;
          w_win_id    = ID_BITS'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_accept)    state_d = c_ISSUE;
      c_ISSUE: if (write_ready) state_d = c_GAP;
      c_GAP:                    state_d = c_IDLE;
      default:                  state_d = c_IDLE;
    endcase
  end

  // reset gates the accept so no req_ready escapes while reset is held.
  always_comb begin
    w_accept    = (state_q == c_IDLE) && write_ready && w_win_found && !reset;
    req_ready   = '0;
    if (w_accept) begin
      req_ready[w_win_id] = 1'b1;
    end
    write_valid = (state_q == c_ISSUE);
    busy        = (state_q != c_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      payload_q <= '0;
      wreset_q  <= 1'b0;
      grant_q   <= c_GRANT_RST;
      locked_q  <= 1'b0;
    end else if (w_accept) begin
      addr_q    <= w_addr_arr[w_win_id];
      payload_q <= w_payload_arr[w_win_id];
      wreset_q  <= req_reset[w_win_id];
      grant_q   <= w_win_id;
      locked_q  <= req_lock[w_win_id];
    end
  end

  assign write_addr    = addr_q;
  assign write_payload = payload_q;
  assign write_reset   = wreset_q;
  assign grant_id      = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_scanchain_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scanchain_write_arbiter
//  Purpose  : Directed scoreboard bench for scanchain_write_arbiter.
//  Revision : 1.0  initial release
// ============================================================================

module tb_scanchain_write_arbiter;

  localparam int AB = 12;
  localparam int PB = 160;

  typedef struct {
    logic [AB-1:0] a;
    logic [PB-1:0] p;
    logic          r;
  } wr_t;

  localparam logic [PB-1:0] PA5 = {20{8'hA5}};
  localparam logic [PB-1:0] P0  = {5{32'h00C0FFEE}};
  localparam logic [PB-1:0] P1  = {5{32'h11110001}};
  localparam logic [PB-1:0] P3  = {5{32'h33330003}};
  localparam logic [PB-1:0] P4  = {5{32'h44440004}};
  localparam logic [PB-1:0] P5  = {5{32'h55550005}};
  localparam logic [PB-1:0] P6  = {5{32'h66660006}};
  localparam logic [PB-1:0] P7  = {5{32'h77770007}};
  localparam logic [PB-1:0] P8  = {5{32'h88880008}};
  localparam logic [PB-1:0] P9  = {5{32'h99990009}};

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*AB-1:0] req_addr;
  logic [2*PB-1:0] req_payload;
  logic [1:0]      req_reset;
  logic [1:0]      req_lock;
  logic            write_ready;
  logic            write_valid;
  logic [AB-1:0]   write_addr;
  logic [PB-1:0]   write_payload;
  logic            write_reset;
  logic [0:0]      grant_id;
  logic            busy;

  scanchain_write_arbiter #(
    .NUM_REQ(2), .ADDR_BITS(AB), .PAYLOAD_BITS(PB)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_payload(req_payload),
    .req_reset(req_reset), .req_lock(req_lock),
    .write_ready(write_ready), .write_valid(write_valid),
    .write_addr(write_addr), .write_payload(write_payload),
    .write_reset(write_reset), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks    = 0;
  int   errors    = 0;
  int   acc_count = 0;
  int   exp_grant [$];
  wr_t  exp_wr    [$];
  int   acc_cyc   [$];
  int   base;

  task automatic chk(input string name, input logic [PB-1:0] act, input logic [PB-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_wr(input logic [AB-1:0] a, input logic [PB-1:0] p, input logic r);
    wr_t w;
    w.a = a; w.p = p; w.r = r;
    exp_wr.push_back(w);
  endtask

  task automatic set_req(input int i, input logic v, input logic [AB-1:0] a,
                         input logic [PB-1:0] p, input logic r, input logic l);
    req_valid[i]            = v;
    req_addr[i*AB +: AB]    = a;
    req_payload[i*PB +: PB] = p;
    req_reset[i]            = r;
    req_lock[i]             = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_count < target && n < budget) begin
      tick();
      n++;
    end
    if (acc_count < target) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got %0d accepts, required %0d", acc_count, target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still high after %0d cycles", budget);
    end
  endtask

  // Monitor: pops the scoreboard on every accept and every completed write.
  logic [1:0] mon_want;
  int         mon_g;
  wr_t        mon_w;
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_quiet", {req_ready, write_valid, busy}, '0);
    end else begin
      if (req_ready != 2'b00) begin
        acc_count++;
        acc_cyc.push_back(cyc);
        chk("ready_in_idle", busy, 1'b0);
        if (exp_grant.size() == 0) begin
          chk("unexpected_grant", req_ready, 2'b00);
        end else begin
          mon_g           = exp_grant.pop_front();
          mon_want        = 2'b00;
          mon_want[mon_g] = 1'b1;
          chk("grant_onehot", req_ready, mon_want);
        end
      end
      if (write_valid && write_ready) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {write_reset, write_addr}, '0);
        end else begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr",    write_addr,    mon_w.a);
          chk("wr_payload", write_payload, mon_w.p);
          chk("wr_reset",   write_reset,   mon_w.r);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; req_payload = '0;
    req_reset = '0; req_lock = '0; write_ready = 1'b1;
    #2;
    chk("rst_busy",    busy,          1'b0);
    chk("rst_wvalid",  write_valid,   1'b0);
    chk("rst_addr",    write_addr,    '0);
    chk("rst_payload", write_payload, '0);
    chk("rst_wreset",  write_reset,   1'b0);
    chk("rst_grant",   grant_id,      1'b1);
    repeat (3) tick();
    reset = 1'b0;

    // Single request: one-cycle write, busy over N+1 and N+2.
    set_req(0, 1'b1, 12'h123, PA5, 1'b1, 1'b0);
    exp_grant.push_back(0);
    push_wr(12'h123, PA5, 1'b1);
    base = acc_count;
    wait_acc(base + 1, 20);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_wv_n1",   write_valid, 1'b1);
    chk("t1_busy_n1", busy,        1'b1);
    @(negedge clk);
    chk("t1_wv_n2",   write_valid, 1'b0);
    chk("t1_busy_n2", busy,        1'b1);
    @(negedge clk);
    chk("t1_busy_n3", busy,        1'b0);
    tick();
    wait_idle(20);

    // Contention from reset: 0,1,0,1 spaced three cycles apart.
    reset = 1'b1;
    tick();
    set_req(0, 1'b1, 12'h100, P0, 1'b0, 1'b0);
    set_req(1, 1'b1, 12'h200, P1, 1'b1, 1'b0);
    exp_grant.push_back(0); exp_grant.push_back(1);
    exp_grant.push_back(0); exp_grant.push_back(1);
    push_wr(12'h100, P0, 1'b0); push_wr(12'h200, P1, 1'b1);
    push_wr(12'h100, P0, 1'b0); push_wr(12'h200, P1, 1'b1);
    tick();
    acc_cyc.delete();
    base = acc_count;
    reset = 1'b0;
    wait_acc(base + 4, 40);
    req_valid = 2'b00;
    if (acc_cyc.size() >= 4) begin
      for (int k = 1; k < 4; k++) chk("t2_spacing", acc_cyc[k] - acc_cyc[k-1], 3);
    end else begin
      chk("t2_accepts", acc_cyc.size(), 4);
    end
    wait_idle(20);

    // Lock: requester 1 served three times while 0 waits, then 0.
    exp_grant.push_back(1); exp_grant.push_back(1);
    exp_grant.push_back(1); exp_grant.push_back(0);
    push_wr(12'h301, P3, 1'b0); push_wr(12'h302, P3, 1'b0);
    push_wr(12'h303, P3, 1'b0); push_wr(12'h0A0, P4, 1'b1);
    base = acc_count;
    set_req(1, 1'b1, 12'h301, P3, 1'b0, 1'b1);
    wait_acc(base + 1, 20);
    set_req(0, 1'b1, 12'h0A0, P4, 1'b1, 1'b0);
    set_req(1, 1'b1, 12'h302, P3, 1'b0, 1'b1);
    wait_acc(base + 2, 20);
    set_req(1, 1'b1, 12'h303, P3, 1'b0, 1'b0);
    wait_acc(base + 3, 20);
    req_valid[1] = 1'b0;
    wait_acc(base + 4, 20);
    req_valid[0] = 1'b0;
    wait_idle(20);

    // Writer stall: five cycles held, transfer on first ready cycle.
    exp_grant.push_back(0);
    push_wr(12'h444, P5, 1'b1);
    base = acc_count;
    set_req(0, 1'b1, 12'h444, P5, 1'b1, 1'b0);
    wait_acc(base + 1, 20);
    write_ready  = 1'b0;
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 12'h777, P6, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_wv_hold",      write_valid,   1'b1);
      chk("t4_addr_hold",    write_addr,    12'h444);
      chk("t4_payload_hold", write_payload, P5);
      chk("t4_wreset_hold",  write_reset,   1'b1);
    end
    tick();
    write_ready  = 1'b1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t4_wv_xfer", write_valid, 1'b1);
    @(negedge clk);
    chk("t4_wv_gap",   write_valid, 1'b0);
    chk("t4_busy_gap", busy,        1'b1);
    tick();
    wait_idle(20);

    // Reset mid-ISSUE: in-flight write dropped, requester 0 wins afterwards.
    exp_grant.push_back(0);
    base = acc_count;
    set_req(0, 1'b1, 12'h555, P7, 1'b1, 1'b0);
    wait_acc(base + 1, 20);
    write_ready = 1'b0;
    #2;
    chk("t5_wv_before", write_valid, 1'b1);
    reset = 1'b1;
    set_req(0, 1'b1, 12'h505, P8, 1'b0, 1'b0);
    set_req(1, 1'b1, 12'h515, P9, 1'b1, 1'b0);
    write_ready = 1'b1;
    #1;
    chk("t5_wv_async",    write_valid, 1'b0);
    chk("t5_busy_async",  busy,        1'b0);
    chk("t5_ready_async", req_ready,   2'b00);
    exp_grant.push_back(0); exp_grant.push_back(1);
    push_wr(12'h505, P8, 1'b0); push_wr(12'h515, P9, 1'b1);
    tick();
    tick();
    base = acc_count;
    reset = 1'b0;
    wait_acc(base + 2, 20);
    req_valid = 2'b00;
    wait_idle(20);

    // Withdrawn request: never granted, never written.
    write_ready = 1'b0;
    set_req(1, 1'b1, 12'h666, P1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_ready_blocked", req_ready,   2'b00);
      chk("t6_wv_blocked",    write_valid, 1'b0);
      tick();
    end
    req_valid[1] = 1'b0;
    write_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_ready_after", req_ready, 2'b00);
      chk("t6_busy_after",  busy,      1'b0);
      tick();
    end

    chk("grant_queue_empty", exp_grant.size(), 0);
    chk("write_queue_empty", exp_wr.size(),    0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scanchain_write_arbiter.md
# scanchain_write_arbiter

Round-robin arbiter that shares the single scanchain writer between `NUM_REQ` independent write sources, such as the UART scan client and an on-board sequencer. It accepts one complete write per grant, presents it to the writer through a held valid/ready handshake, and enforces a turnaround cycle between writes. A per-requester lock lets one source issue back-to-back writes without interleaving.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, at least 2.
- `ADDR_BITS`, default 12: scan address width.
- `PAYLOAD_BITS`, default 160: scan payload width.
- `ID_BITS`, default `$clog2(NUM_REQ)`: width of `grant_id`.

Ports (`clk` and `reset` listed first):
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  NUM_REQ  bit i: requester i has a write pending.
- `req_ready`  out  NUM_REQ  bit i: requester i's write is accepted this cycle (combinational).
- `req_addr`  in  NUM_REQ*ADDR_BITS  requester i occupies slice `[i*ADDR_BITS +: ADDR_BITS]`.
- `req_payload`  in  NUM_REQ*PAYLOAD_BITS  requester i occupies slice `[i*PAYLOAD_BITS +: PAYLOAD_BITS]`.
- `req_reset`  in  NUM_REQ  per-requester scan reset bit.
- `req_lock`  in  NUM_REQ  requester i asks to keep the grant after the current write.
- `write_ready`  in  1  the writer is idle and can accept a write.
- `write_valid`  out  1  write presented to the writer.
- `write_addr`  out  ADDR_BITS  registered address.
- `write_payload`  out  PAYLOAD_BITS  registered payload.
- `write_reset`  out  1  registered scan reset bit.
- `grant_id`  out  ID_BITS  index of the last accepted requester.
- `busy`  out  1  high when the state is not IDLE.

## Operation
State machine with three states:
- **IDLE**
  - If `write_ready` is high and any `req_valid` is high, select a winner `w`.
  - Assert `req_ready[w]` combinationally. Only one bit of `req_ready` may ever be high.
  - On that edge, capture `addr`, `payload` and `reset` from requester `w`. Set `grant_id <= w` and `locked <= req_lock[w]`. Go to ISSUE.
  - If `write_ready` is low, `req_ready` is all zero and the state stays IDLE.
- **ISSUE**
  - `write_valid` is high, and the output fields are stable.
  - Leave on the edge where `write_valid && write_ready`. Go to GAP.
  - `write_valid` stays high across writer stalls of any length.
- **GAP**
  - Lasts exactly one cycle, then returns to IDLE.
  - Gives the writer one cycle to deassert `write_ready` after accepting.

Winner selection:
- When `locked` is set, only requester `grant_id` is eligible.
  - If it is not valid, the arbiter waits; other requesters are not served.
  - The lock drops when that requester is accepted with `req_lock` low.
- When `locked` is clear, selection is round-robin. Search from `grant_id+1` upward, modulo `NUM_REQ`, and take the first valid requester.
- A requester that deasserts `req_valid` before it is accepted is simply skipped. No state is kept for it.

Other rules:
- `req_ready` is never high outside IDLE.
- Changes to the `req_*` inputs after acceptance do not affect the write in flight.

## Timing
Reset values:
- state IDLE
- `write_valid` 0
- `write_addr`, `write_payload`, `write_reset` 0
- `grant_id` = `NUM_REQ-1`, so requester 0 has first priority
- `locked` 0
- `busy` 0

Latency:
- Accept in cycle N.
- `write_valid` is high in N+1.
- If `write_ready` is high in N+1, the transfer completes at the end of N+1.
- GAP is cycle N+2.
- The earliest next accept is N+3. Peak throughput is one write per 3 cycles.

Writer stall: each cycle in ISSUE with `write_ready` low adds one cycle. Outputs are held throughout.

Simultaneous events: two requests raised in the same cycle are served in round-robin order, never the same requester twice in a row while the other is pending (unless it holds the lock).

Reset: assertion at any time, including mid-ISSUE, returns to reset values immediately. The write in flight is dropped and no `req_ready` is asserted. Deassertion is assumed synchronised externally.

## Test plan
- **Single request.** Requester 0 sends addr 0x123, payload 0xA5…A5, reset 1, with `write_ready` high. Required: `req_ready[0]` high in cycle N; `write_valid` high for exactly one cycle at N+1 carrying 0x123, 0xA5…A5, 1; `busy` high for N+1 and N+2.
- **Contention.** Both requesters are held valid for 4 writes, starting from reset. Required: grant order 0,1,0,1, with accepts spaced exactly 3 cycles apart.
- **Lock.** Requester 1 keeps `req_lock` high for 3 writes while requester 0 is valid throughout. Required: requester 1 is served 3 times in a row; requester 0 is served next, after the third write is accepted with `req_lock` low.
- **Writer stall.** Hold `write_ready` low for 5 cycles during ISSUE. Required: `write_valid` and all fields are held for the 5 cycles; `req_ready` stays low; the transfer happens on the first cycle `write_ready` is high.
- **Reset mid-ISSUE.** Assert `reset` while `write_valid` is high. Required: `write_valid`, `busy` and `req_ready` go to 0 without waiting for a clock edge; after release, requester 0 wins a simultaneous 0/1 request.
- **Withdrawn request.** Requester 1 drops `req_valid` while IDLE is blocked by `write_ready` low. Required: no `req_ready[1]` pulse and no write issued for requester 1.
